aes_round_sched: RTL and testbench

- Iterative AES-128 encryption round scheduler.
- Owns the 128-bit cipher state register and the round counter.
- Each round it drives the shared registered round datapath (subbytes -> shiftrows -> mixcolumns), waits the fixed pipeline latency, then folds in the round key.
- Sits between the block-level valid/ready stream and the round datapath / round-key table.

---
 rtl/aes_round_sched_if.sv | 30 +++
 rtl/aes_round_sched.sv | 115 +++++++++++
 tb/tb_aes_round_sched.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_sched_if.sv
// Bundle of stream, datapath and key-table signals around the AES round scheduler.
// The scheduler takes the slave view; the surrounding environment takes the master view.
interface aes_round_sched_if #(
  parameter int DW = 128
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          flush;
  logic [3:0]    rk_idx;
  logic [DW-1:0] rk_in;
  logic          rnd_go;
  logic [DW-1:0] rnd_in;
  logic          last_round;
  logic [DW-1:0] rnd_out;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;

  modport master (
    output in_valid, in_data, flush, rk_in, rnd_out, out_ready,
    input  in_ready, rk_idx, rnd_go, rnd_in, last_round, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, flush, rk_in, rnd_out, out_ready,
    output in_ready, rk_idx, rnd_go, rnd_in, last_round, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_round_sched.sv
// Iterative AES-128 round scheduler: owns the cipher state and round counter,
// launches one round at a time into an external registered datapath and folds
// in the round key when the datapath result is due.
//
// state | meaning
// IDLE  | waiting for a plaintext block, rk_idx = 0
// ISSUE | rnd_go pulse, datapath starts on rnd_in
// WAIT  | counting down datapath latency, capture rnd_out ^ rk_in at zero
// DONE  | ciphertext presented until the consumer takes it
module aes_round_sched #(
  parameter int NR        = 10,
  parameter int STAGE_LAT = 3,
  parameter int DW        = 128
) (
  input logic              clk,
  input logic              rst,
  aes_round_sched_if.slave bus
);
  localparam int              CW       = $clog2(STAGE_LAT) + 1;
  localparam logic [3:0]      LAST_IDX = 4'(NR);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(STAGE_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [DW-1:0] state_reg;
  logic [3:0]    rk_idx;
  logic [CW-1:0] cnt;
  logic          rnd_go;
  logic          out_valid;
  logic          in_ready;

  // Sequencer: state, round index, latency counter and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      state_reg <= '0;
      rk_idx    <= '0;
      cnt       <= '0;
      rnd_go    <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else if (bus.flush) begin
      // Abort wins over everything, including a block offered in IDLE.
      // state_reg is left as is; nothing is emitted.
      state     <= S_IDLE;
      rk_idx    <= '0;
      cnt       <= '0;
      rnd_go    <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid && in_ready) begin
            state_reg <= bus.in_data ^ bus.rk_in;
            rk_idx    <= 4'd1;
            rnd_go    <= 1'b1;
            in_ready  <= 1'b0;
            state     <= S_ISSUE;
          end else begin
            rk_idx   <= '0;
            in_ready <= 1'b1;
          end
        end
        S_ISSUE: begin
          rnd_go <= 1'b0;
          cnt    <= CNT_LOAD;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state_reg <= bus.rnd_out ^ bus.rk_in;
            if (rk_idx == LAST_IDX) begin
              state <= S_DONE;
            end else begin
              rk_idx <= rk_idx + 4'd1;
              rnd_go <= 1'b1;
              state  <= S_ISSUE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          // out_valid rises one cycle after the final capture and holds until taken.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid <= 1'b0;
            rk_idx    <= '0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are straight views of registers; rnd_in/out_data only move on capture.
  assign bus.in_ready   = in_ready;
  assign bus.rk_idx     = rk_idx;
  assign bus.rnd_go     = rnd_go;
  assign bus.rnd_in     = state_reg;
  assign bus.last_round = (rk_idx == LAST_IDX);
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = state_reg;
  assign bus.busy       = (state != S_IDLE);
endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: a software AES-128 (key expansion + full cipher) is the
// reference, a STAGE_LAT-deep round-function pipeline stands in for the datapath, and
// three scheduler instances cover STAGE_LAT = 3 (main), 1 and 5.
module tb_aes_round_sched;
  localparam int NR = 10;
  localparam int DW = 128;
  localparam logic [127:0] JUNK     = 128'hdead_beef_dead_beef_dead_beef_dead_beef;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_round_sched_if #(.DW(DW)) b3 ();
  aes_round_sched_if #(.DW(DW)) b1 ();
  aes_round_sched_if #(.DW(DW)) b5 ();

  aes_round_sched #(.NR(NR), .STAGE_LAT(3), .DW(DW)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));
  aes_round_sched #(.NR(NR), .STAGE_LAT(1), .DW(DW)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  aes_round_sched #(.NR(NR), .STAGE_LAT(5), .DW(DW)) u5 (.clk(clk), .rst(rst), .bus(b5.slave));

  logic [7:0]   sb [256];
  logic [127:0] rk_tab [16];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = xt(x);
    end
    return r;
  endfunction

  // SubBytes -> ShiftRows -> MixColumns (skipped on the last round); no key add.
  function automatic logic [127:0] rnd_fn(input logic [127:0] x, input logic last);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] t0, t1, t2, t3;
    logic [127:0] y;
    for (int i = 0; i < 16; i++) a[i] = sb[x[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        t0 = b[4*c]; t1 = b[4*c+1]; t2 = b[4*c+2]; t3 = b[4*c+3];
        b[4*c]   = gm(t0, 8'd2) ^ gm(t1, 8'd3) ^ t2 ^ t3;
        b[4*c+1] = t0 ^ gm(t1, 8'd2) ^ gm(t2, 8'd3) ^ t3;
        b[4*c+2] = t0 ^ t1 ^ gm(t2, 8'd2) ^ gm(t3, 8'd3);
        b[4*c+3] = gm(t0, 8'd3) ^ t1 ^ t2 ^ gm(t3, 8'd2);
      end
    end
    for (int i = 0; i < 16; i++) y[127-8*i -: 8] = b[i];
    return y;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk_tab[0];
    for (int r = 1; r <= NR; r++) s = rnd_fn(s, r == NR) ^ rk_tab[r];
    return s;
  endfunction

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int r = NR + 1; r < 16; r++) rk_tab[r] = '0;
  endtask

  // Key table lookup (combinational) and datapath pipelines per instance.
  assign b3.rk_in = rk_tab[b3.rk_idx];
  assign b1.rk_in = rk_tab[b1.rk_idx];
  assign b5.rk_in = rk_tab[b5.rk_idx];

  logic [127:0] p3 [3];
  logic [127:0] p1;
  logic [127:0] p5 [5];

  always @(posedge clk) begin
    p3[0] <= b3.rnd_go ? rnd_fn(b3.rnd_in, b3.last_round) : JUNK;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    p1    <= b1.rnd_go ? rnd_fn(b1.rnd_in, b1.last_round) : JUNK;
    p5[0] <= b5.rnd_go ? rnd_fn(b5.rnd_in, b5.last_round) : JUNK;
    for (int i = 1; i < 5; i++) p5[i] <= p5[i-1];
  end
  assign b3.rnd_out = p3[2];
  assign b1.rnd_out = p1;
  assign b5.rnd_out = p5[4];

  // Record every rnd_go pulse of the main instance.
  int         go_cyc [$];
  logic [3:0] go_idx [$];
  logic       go_last [$];
  always @(negedge clk) begin
    if (b3.rnd_go) begin
      go_cyc.push_back(cyc);
      go_idx.push_back(b3.rk_idx);
      go_last.push_back(b3.last_round);
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer a block to the main instance right after a negedge; returns acceptance cycle.
  task automatic start3(input logic [127:0] pt, output int e);
    b3.in_valid = 1'b1;
    b3.in_data  = pt;
    @(negedge clk);
    chk("accept_busy", 128'(b3.busy), 128'd1);
    e = cyc;
    b3.in_valid = 1'b0;
  endtask

  task automatic wait_out3(input int e, output int lat);
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (b3.out_valid) begin
        lat = cyc - e;
        break;
      end
    end
  endtask

  task automatic take3();
    b3.out_ready = 1'b1;
    @(negedge clk);
    b3.out_ready = 1'b0;
    chk("idle_after_take", 128'({b3.busy, b3.out_valid, b3.in_ready}), 128'b001);
  endtask

  task automatic wait_round3(input logic [3:0] idx);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (b3.rnd_go && b3.rk_idx == idx) break;
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"},  128'(b3.busy), 128'd0);
    chk({tag, "_ovalid"}, 128'(b3.out_valid), 128'd0);
    chk({tag, "_go"},    128'(b3.rnd_go), 128'd0);
    chk({tag, "_rkidx"}, 128'(b3.rk_idx), 128'd0);
    chk({tag, "_last"},  128'(b3.last_round), 128'd0);
    chk({tag, "_odata"}, b3.out_data, 128'd0);
    chk({tag, "_rndin"}, b3.rnd_in, 128'd0);
  endtask

  initial begin
    int e, lat, nov;
    logic [127:0] pt, pt2, exp_ct;
    logic [7:0] inv;

    for (int i = 0; i < 256; i++) begin
      inv = 8'h00;
      for (int j = 1; j < 256; j++) if (gm(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
      sb[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    set_key(FIPS_KEY);

    rst = 1'b1;
    b3.in_valid = 0; b3.in_data = '0; b3.flush = 0; b3.out_ready = 0;
    b1.in_valid = 0; b1.in_data = '0; b1.flush = 0; b1.out_ready = 0;
    b5.in_valid = 0; b5.in_data = '0; b5.flush = 0; b5.out_ready = 0;
    repeat (3) @(negedge clk);
    reset_checks("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 128'(b3.in_ready), 128'd1);

    // FIPS-197 vector, sequencing and back-pressure.
    go_cyc.delete(); go_idx.delete(); go_last.delete();
    start3(FIPS_PT, e);
    wait_out3(e, lat);
    chk("fips_latency", 128'(lat), 128'd41);
    chk("fips_ct", b3.out_data, FIPS_CT);
    chk("fips_model", aes_ref(FIPS_PT), FIPS_CT);
    chk("go_count", 128'(go_cyc.size()), 128'd10);
    if (go_cyc.size() > 0) chk("first_go", 128'(go_cyc[0] - e), 128'd0);
    for (int i = 0; i < go_cyc.size(); i++) begin
      if (i > 0) chk("go_spacing", 128'(go_cyc[i] - go_cyc[i-1]), 128'd4);
      chk("go_rkidx", 128'(go_idx[i]), 128'(i + 1));
      chk("go_last", 128'(go_last[i]), 128'(i == NR - 1));
    end
    for (int i = 0; i < 20; i++) begin
      chk("bp_data", b3.out_data, FIPS_CT);
      chk("bp_flags", 128'({b3.out_valid, b3.in_ready}), 128'b10);
      @(negedge clk);
    end
    take3();
    chk("idle_rkidx", 128'(b3.rk_idx), 128'd0);

    // Back-to-back: in_valid held high, second block waits for the first handshake.
    set_key({$urandom, $urandom, $urandom, $urandom});
    pt  = {$urandom, $urandom, $urandom, $urandom};
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    b3.in_valid = 1'b1;
    b3.in_data  = pt;
    @(negedge clk);
    chk("b2b_accept_a", 128'(b3.busy), 128'd1);
    e = cyc;
    b3.in_data = pt2;
    wait_out3(e, lat);
    chk("b2b_lat_a", 128'(lat), 128'd41);
    chk("b2b_ct_a", b3.out_data, aes_ref(pt));
    repeat (3) begin
      @(negedge clk);
      chk("b2b_hold_ready", 128'(b3.in_ready), 128'd0);
    end
    b3.out_ready = 1'b1;
    @(negedge clk);
    b3.out_ready = 1'b0;
    chk("b2b_gap", 128'({b3.busy, b3.in_ready}), 128'b01);
    @(negedge clk);
    chk("b2b_accept_b", 128'(b3.busy), 128'd1);
    e = cyc;
    b3.in_valid = 1'b0;
    wait_out3(e, lat);
    chk("b2b_lat_b", 128'(lat), 128'd41);
    chk("b2b_ct_b", b3.out_data, aes_ref(pt2));
    take3();

    // Randomized blocks with random consumer stall.
    for (int n = 0; n < 3; n++) begin
      set_key({$urandom, $urandom, $urandom, $urandom});
      pt = {$urandom, $urandom, $urandom, $urandom};
      exp_ct = aes_ref(pt);
      start3(pt, e);
      wait_out3(e, lat);
      chk("rand_lat", 128'(lat), 128'd41);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      chk("rand_ct", b3.out_data, exp_ct);
      take3();
    end

    // Flush in WAIT of round 5.
    pt = {$urandom, $urandom, $urandom, $urandom};
    start3(pt, e);
    wait_round3(4'd5);
    @(negedge clk);
    chk("flush_pre", 128'({b3.busy, b3.rnd_go, b3.rk_idx}), 128'({1'b1, 1'b0, 4'd5}));
    b3.flush = 1'b1;
    @(negedge clk);
    b3.flush = 1'b0;
    chk("flush_idle", 128'({b3.busy, b3.out_valid, b3.rk_idx}), 128'd0);
    nov = 0;
    repeat (60) begin
      @(negedge clk);
      if (b3.out_valid) nov++;
    end
    chk("flush_no_out", 128'(nov), 128'd0);
    b3.flush = 1'b1;
    b3.in_valid = 1'b1;
    b3.in_data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    b3.flush = 1'b0;
    chk("flush_wins", 128'(b3.busy), 128'd0);
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    b3.in_data = pt2;
    @(negedge clk);
    chk("post_flush_accept", 128'(b3.busy), 128'd1);
    e = cyc;
    b3.in_valid = 1'b0;
    wait_out3(e, lat);
    chk("post_flush_lat", 128'(lat), 128'd41);
    chk("post_flush_ct", b3.out_data, aes_ref(pt2));
    take3();

    // Asynchronous reset in round 7.
    pt = {$urandom, $urandom, $urandom, $urandom};
    start3(pt, e);
    wait_round3(4'd7);
    rst = 1'b1;
    #1;
    reset_checks("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 128'(b3.in_ready), 128'd1);
    nov = 0;
    repeat (60) begin
      @(negedge clk);
      if (b3.out_valid) nov++;
    end
    chk("midrst_no_out", 128'(nov), 128'd0);

    // Latency overrides on the FIPS vector.
    set_key(FIPS_KEY);
    b1.in_valid = 1'b1;
    b1.in_data  = FIPS_PT;
    @(negedge clk);
    chk("sl1_accept", 128'(b1.busy), 128'd1);
    e = cyc;
    b1.in_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (b1.out_valid) begin
        lat = cyc - e;
        break;
      end
    end
    chk("sl1_latency", 128'(lat), 128'd21);
    chk("sl1_ct", b1.out_data, FIPS_CT);
    b1.out_ready = 1'b1;
    @(negedge clk);
    b1.out_ready = 1'b0;
    chk("sl1_idle", 128'(b1.busy), 128'd0);

    b5.in_valid = 1'b1;
    b5.in_data  = FIPS_PT;
    @(negedge clk);
    chk("sl5_accept", 128'(b5.busy), 128'd1);
    e = cyc;
    b5.in_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (b5.out_valid) begin
        lat = cyc - e;
        break;
      end
    end
    chk("sl5_latency", 128'(lat), 128'd61);
    chk("sl5_ct", b5.out_data, FIPS_CT);
    b5.out_ready = 1'b1;
    @(negedge clk);
    b5.out_ready = 1'b0;
    chk("sl5_idle", 128'(b5.busy), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
